regfile_wport_arbiter: RTL and testbench

- Shares the integer register file's two write ports between the in-order pipeline writeback and a long-latency unit (divider/multi-cycle ops) that returns results out of band.
- Pipeline writes always have priority and pass straight through in the same cycle.
- Long-latency results are buffered in a small FIFO and drained into whichever write port the pipeline leaves idle.
- Provides a pending-register mask for hazard detection, and a starvation hold request that stalls the pipeline when buffered results cannot drain.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_wport_arbiter_if.sv | 40 ++++
 rtl/regfile_wport_arbiter_wb_fifo.sv | 61 ++++++
 rtl/regfile_wport_arbiter.sv | 97 +++++++++
 tb/tb_regfile_wport_arbiter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file definitions for the write-port arbiter slice.
//   REG_ADDR_W / REG_DATA_W : register address and data widths
//   REG_ZERO                : hard-wired zero register; writes to it are dropped
//   NUM_REGS                : register count (width of the pending mask)
//   wr_t                    : one register write {addr, data}
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wr_t;
endpackage

// File: rtl/regfile_wport_arbiter_if.sv
// Bus between the pipeline / long-latency unit (master) and the write-port
// arbiter (slave).
//   p_*      : pipeline writeback ports 0 and 1
//   lu_*     : long-latency result handshake
//   wen/waddr/wdata : arbitrated regfile write ports 0 and 1
//   pend_mask, pipe_hold, fifo_count : hazard/stall status
interface regfile_wport_arbiter_if
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  p_wen0, p_wen1;
  logic [REG_ADDR_W-1:0] p_waddr0, p_waddr1;
  logic [REG_DATA_W-1:0] p_wdata0, p_wdata1;
  logic                  lu_valid, lu_ready;
  logic [REG_ADDR_W-1:0] lu_waddr;
  logic [REG_DATA_W-1:0] lu_wdata;
  logic                  wen0, wen1;
  logic [REG_ADDR_W-1:0] waddr0, waddr1;
  logic [REG_DATA_W-1:0] wdata0, wdata1;
  logic [NUM_REGS-1:0]   pend_mask;
  logic                  pipe_hold;
  logic [CW-1:0]         fifo_count;

  modport master (
    output p_wen0, p_waddr0, p_wdata0, p_wen1, p_waddr1, p_wdata1,
    output lu_valid, lu_waddr, lu_wdata,
    input  lu_ready, wen0, waddr0, wdata0, wen1, waddr1, wdata1,
    input  pend_mask, pipe_hold, fifo_count
  );

  modport slave (
    input  p_wen0, p_waddr0, p_wdata0, p_wen1, p_waddr1, p_wdata1,
    input  lu_valid, lu_waddr, lu_wdata,
    output lu_ready, wen0, waddr0, wdata0, wen1, waddr1, wdata1,
    output pend_mask, pipe_hold, fifo_count
  );
endinterface

// File: rtl/regfile_wport_arbiter_wb_fifo.sv
// wb_fifo: synchronous FIFO of pending register writes.
//   clk, rst      : clock, synchronous active-high reset (empties the FIFO)
//   push, wr_in   : enqueue (caller guarantees !full)
//   pop, head     : dequeue / oldest entry (valid when !empty)
//   full, empty, count : occupancy
//   ent_vld, ent_addr  : per-slot valid flag and destination, for the mask
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 push,
  input  wr_t                                  wr_in,
  input  logic                                 pop,
  output wr_t                                  head,
  output logic                                 full,
  output logic                                 empty,
  output logic [CW-1:0]                        count,
  output logic [DEPTH-1:0]                     ent_vld,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]     ent_addr
);
  wr_t           mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;

  // Storage needs no reset: slots are only observed through ent_vld/count.
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_in;

  // Pointers wrap naturally at DEPTH (power of two); count separates full/empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Slot i is live when its distance from the read pointer is below count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [AW-1:0] off;
    assign off         = AW'(i) - rd_ptr;
    assign ent_vld[i]  = {1'b0, off} < count;
    assign ent_addr[i] = mem[i].addr;
  end
endmodule

// File: rtl/regfile_wport_arbiter.sv
// regfile_wport_arbiter: shares the two regfile write ports between the
// pipeline writeback (always wins, zero latency) and buffered long-latency
// results, which drain into whichever port the pipeline leaves idle.
//   clk, rst : clock, synchronous active-high reset
//   clk_en   : state-update enable (FIFO, starve counter, pipe_hold)
//   bus      : slave side of regfile_wport_arbiter_if
module regfile_wport_arbiter
  import regfile_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  regfile_wport_arbiter_if.slave  bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

  logic pe0, pe1, clash, drain_ok, drain0, drain1, pop, push, full, empty;
  wr_t  head, lu_wr;
  logic [CW-1:0]                    count;
  logic [DEPTH-1:0]                 ent_vld;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_addr;
  logic [SW-1:0]                    starve_cnt;
  logic                             hold_q;

  // r0 writes are architecturally void, so they do not occupy a port.
  assign pe0 = bus.p_wen0 && (bus.p_waddr0 != REG_ZERO);
  assign pe1 = bus.p_wen1 && (bus.p_waddr1 != REG_ZERO);

  // Draining the head past a same-cycle pipeline write to the same register
  // would let the older result land alongside (or after) the newer one.
  assign clash    = (pe0 && bus.p_waddr0 == head.addr) ||
                    (pe1 && bus.p_waddr1 == head.addr);
  assign drain_ok = clk_en && !rst && !empty && !clash;
  assign drain0   = drain_ok && !pe0;
  assign drain1   = drain_ok && pe0 && !pe1;
  assign pop      = drain0 || drain1;

  // Ready deliberately ignores pop so it never depends on pipeline inputs.
  assign bus.lu_ready = !full && !rst;
  assign push         = bus.lu_valid && bus.lu_ready && clk_en &&
                        (bus.lu_waddr != REG_ZERO);
  assign lu_wr        = '{addr: bus.lu_waddr, data: bus.lu_wdata};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .wr_in    (lu_wr),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .ent_vld  (ent_vld),
    .ent_addr (ent_addr)
  );

  assign bus.wen0   = pe0 || drain0;
  assign bus.waddr0 = drain0 ? head.addr : bus.p_waddr0;
  assign bus.wdata0 = drain0 ? head.data : bus.p_wdata0;
  assign bus.wen1   = pe1 || drain1;
  assign bus.waddr1 = drain1 ? head.addr : bus.p_waddr1;
  assign bus.wdata1 = drain1 ? head.data : bus.p_wdata1;

  // Mask is built from FIFO registers, so it moves at the push/pop edge and
  // an entry draining this cycle is still flagged this cycle.
  always_comb begin
    bus.pend_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_vld[i]) bus.pend_mask[ent_addr[i]] = 1'b1;
  end

  // Starvation: count non-draining cycles with work queued; hold the
  // pipeline once the limit is reached until the next drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      hold_q     <= 1'b0;
    end else if (clk_en) begin
      if (empty || pop) begin
        starve_cnt <= '0;
        if (pop) hold_q <= 1'b0;
      end else if (starve_cnt != LIM) begin
        starve_cnt <= starve_cnt + 1'b1;
        if (starve_cnt == LIM - 1'b1) hold_q <= 1'b1;
      end
    end
  end

  assign bus.pipe_hold  = hold_q;
  assign bus.fifo_count = count;
endmodule

// File: tb/tb_regfile_wport_arbiter.sv
module tb_regfile_wport_arbiter;
  import regfile_pkg::*;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic clk = 1'b0;
  logic rst, clk_en;
  always #5 clk = ~clk;

  regfile_wport_arbiter_if #(.DEPTH(DEPTH)) bus ();
  regfile_wport_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: queue of pending writes plus a starvation cycle count.
  logic [4:0]  qa[$];
  logic [31:0] qd[$];
  int          starve = 0;
  logic        m_d0, m_d1, m_rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    bus.p_wen0 = w0; bus.p_waddr0 = a0; bus.p_wdata0 = d0;
    bus.p_wen1 = w1; bus.p_waddr1 = a1; bus.p_wdata1 = d1;
    bus.lu_valid = lv; bus.lu_waddr = la; bus.lu_wdata = ld;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // Compare every DUT output against the model, mid-cycle.
  task automatic sample();
    logic p0, p1, ok;
    logic [31:0] mask;
    @(negedge clk);
    p0 = bus.p_wen0 && bus.p_waddr0 != 5'd0;
    p1 = bus.p_wen1 && bus.p_waddr1 != 5'd0;
    ok = !rst && clk_en && qa.size() > 0;
    if (ok && ((p0 && qa[0] == bus.p_waddr0) || (p1 && qa[0] == bus.p_waddr1))) ok = 1'b0;
    m_d0  = ok && !p0;
    m_d1  = ok && p0 && !p1;
    m_rdy = !rst && qa.size() < DEPTH;
    mask = '0;
    foreach (qa[i]) mask[qa[i]] = 1'b1;
    chk("wen0", 32'(bus.wen0), 32'(p0 || m_d0));
    if (p0 || m_d0) begin
      chk("waddr0", 32'(bus.waddr0), m_d0 ? 32'(qa[0]) : 32'(bus.p_waddr0));
      chk("wdata0", bus.wdata0, m_d0 ? qd[0] : bus.p_wdata0);
    end
    chk("wen1", 32'(bus.wen1), 32'(p1 || m_d1));
    if (p1 || m_d1) begin
      chk("waddr1", 32'(bus.waddr1), m_d1 ? 32'(qa[0]) : 32'(bus.p_waddr1));
      chk("wdata1", bus.wdata1, m_d1 ? qd[0] : bus.p_wdata1);
    end
    chk("lu_ready", 32'(bus.lu_ready), 32'(m_rdy));
    chk("pend_mask", bus.pend_mask, mask);
    chk("fifo_count", 32'(bus.fifo_count), 32'(qa.size()));
    chk("pipe_hold", 32'(bus.pipe_hold), 32'(starve == LIMIT));
  endtask

  task automatic advance();
    if (rst) begin
      qa.delete(); qd.delete(); starve = 0;
    end else if (clk_en) begin
      bit ne;
      ne = qa.size() > 0;
      if (m_d0 || m_d1) begin
        void'(qa.pop_front()); void'(qd.pop_front());
      end
      if (bus.lu_valid && m_rdy && bus.lu_waddr != 5'd0) begin
        qa.push_back(bus.lu_waddr); qd.push_back(bus.lu_wdata);
      end
      if (!ne || m_d0 || m_d1) starve = 0;
      else if (starve < LIMIT) starve++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b1; idle();
    // reset state
    sample();
    chk("rst_ready", 32'(bus.lu_ready), 32'd0);
    chk("rst_count", 32'(bus.fifo_count), 32'd0);
    chk("rst_hold", 32'(bus.pipe_hold), 32'd0);
    advance();
    rst = 1'b0;
    sample(); chk("ready_after_rst", 32'(bus.lu_ready), 32'd1); advance();

    // push r5, drains next cycle on port 0
    drive(0, 0, 0, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
    sample(); chk("s1_push_wen0", 32'(bus.wen0), 32'd0); advance();
    idle();
    sample();
    chk("s1_wen0", 32'(bus.wen0), 32'd1);
    chk("s1_waddr0", 32'(bus.waddr0), 32'd5);
    chk("s1_wdata0", bus.wdata0, 32'hDEADBEEF);
    chk("s1_mask", bus.pend_mask, 32'h20);
    chk("s1_count", 32'(bus.fifo_count), 32'd1);
    advance();
    sample();
    chk("s1_count0", 32'(bus.fifo_count), 32'd0);
    chk("s1_mask0", bus.pend_mask, 32'd0);
    advance();

    // head r7 drains on port 1 beside pipeline r3
    drive(0, 0, 0, 0, 0, 0, 1, 5'd7, 32'h777);
    tick();
    drive(1, 5'd3, 32'h33, 0, 0, 0, 0, 0, 0);
    sample();
    chk("s2_wen1", 32'(bus.wen1), 32'd1);
    chk("s2_waddr1", 32'(bus.waddr1), 32'd7);
    chk("s2_wdata1", bus.wdata1, 32'h777);
    chk("s2_waddr0", 32'(bus.waddr0), 32'd3);
    advance();

    // head r9 collides with pipeline r9: waits a cycle
    drive(0, 0, 0, 0, 0, 0, 1, 5'd9, 32'h999);
    tick();
    drive(1, 5'd9, 32'h90, 0, 0, 0, 0, 0, 0);
    sample();
    chk("s3_wen1", 32'(bus.wen1), 32'd0);
    chk("s3_count", 32'(bus.fifo_count), 32'd1);
    chk("s3_mask", bus.pend_mask, 32'h200);
    advance();
    idle();
    sample();
    chk("s3_waddr0", 32'(bus.waddr0), 32'd9);
    chk("s3_wdata0", bus.wdata0, 32'h999);
    advance();
    tick();

    // both ports busy: fill, starve, hold, then release
    for (int i = 0; i <= 10; i++) begin
      drive(1, 5'd1, 32'(i), 1, 5'd2, 32'(i), 1, (i < 4) ? 5'(10 + i) : 5'd14, 32'(32'h100 + i));
      sample();
      if (i == 4) begin
        chk("s4_ready_full", 32'(bus.lu_ready), 32'd0);
        chk("s4_count_full", 32'(bus.fifo_count), 32'd4);
      end
      if (i == 8)  chk("s4_hold_pre", 32'(bus.pipe_hold), 32'd0);
      if (i == 10) chk("s4_hold", 32'(bus.pipe_hold), 32'd1);
      advance();
    end
    idle();
    sample();
    chk("s4_drain_wen0", 32'(bus.wen0), 32'd1);
    chk("s4_drain_addr", 32'(bus.waddr0), 32'd10);
    chk("s4_hold_drain", 32'(bus.pipe_hold), 32'd1);
    advance();
    sample(); chk("s4_hold_clr", 32'(bus.pipe_hold), 32'd0); advance();
    tick(); tick();
    sample(); chk("s4_empty", 32'(bus.fifo_count), 32'd0); advance();

    // r0 results dropped; r0 pipeline writes free port 0
    drive(0, 0, 0, 0, 0, 0, 1, 5'd0, 32'h1234);
    sample(); chk("s5_ready", 32'(bus.lu_ready), 32'd1); advance();
    idle();
    sample(); chk("s5_nopush", 32'(bus.fifo_count), 32'd0); advance();
    drive(0, 0, 0, 0, 0, 0, 1, 5'd20, 32'h2020);
    tick();
    drive(1, 5'd0, 32'hAA, 1, 5'd21, 32'h21, 0, 0, 0);
    sample();
    chk("s5_wen0", 32'(bus.wen0), 32'd1);
    chk("s5_waddr0", 32'(bus.waddr0), 32'd20);
    chk("s5_wdata0", bus.wdata0, 32'h2020);
    chk("s5_waddr1", 32'(bus.waddr1), 32'd21);
    advance();
    drive(1, 5'd0, 32'hAA, 1, 5'd0, 32'hBB, 0, 0, 0);
    sample();
    chk("s5_r0_wen0", 32'(bus.wen0), 32'd0);
    chk("s5_r0_wen1", 32'(bus.wen1), 32'd0);
    advance();

    // clk_en low freezes push and drain
    clk_en = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1, 5'd6, 32'h66);
    tick();
    clk_en = 1'b1; idle();
    sample(); chk("s6_no_push", 32'(bus.fifo_count), 32'd0); advance();
    drive(0, 0, 0, 0, 0, 0, 1, 5'd6, 32'h66);
    tick();
    clk_en = 1'b0; idle();
    sample();
    chk("s6_no_drain", 32'(bus.wen0), 32'd0);
    chk("s6_count", 32'(bus.fifo_count), 32'd1);
    advance();
    tick();
    clk_en = 1'b1;
    sample(); chk("s6_drain", 32'(bus.waddr0), 32'd6); advance();

    // pointer wrap: steady push with drains on alternate cycles via port 1
    for (int i = 0; i < 12; i++) begin
      drive(1, 5'd1, 32'h11, (i % 2) == 0, 5'd2, 32'h22, 1, 5'(16 + i), 32'(32'h1000 + i));
      tick();
    end
    idle();
    for (int i = 0; i < 5; i++) tick();
    sample(); chk("s7_empty", 32'(bus.fifo_count), 32'd0); advance();

    // reset with entries buffered and hold raised
    for (int i = 0; i < 12; i++) begin
      drive(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, i < 3, 5'(24 + i), 32'(32'h2400 + i));
      sample();
      if (i == 11) begin
        chk("s8_hold", 32'(bus.pipe_hold), 32'd1);
        chk("s8_count", 32'(bus.fifo_count), 32'd3);
        chk("s8_mask", bus.pend_mask, 32'h0700_0000);
      end
      advance();
    end
    rst = 1'b1; idle();
    sample();
    chk("s8_rst_ready", 32'(bus.lu_ready), 32'd0);
    chk("s8_rst_wen0", 32'(bus.wen0), 32'd0);
    advance();
    rst = 1'b0;
    sample();
    chk("s8_post_count", 32'(bus.fifo_count), 32'd0);
    chk("s8_post_mask", bus.pend_mask, 32'd0);
    chk("s8_post_hold", 32'(bus.pipe_hold), 32'd0);
    chk("s8_post_ready", 32'(bus.lu_ready), 32'd1);
    advance();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
